// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared encodings for the multi-cycle MIPS control unit.
//   - state_t: FSM state codes (also exported on the debug state port)
//   - opcode / funct constants used by the decoder
//   - default I/O page and I/O timeout
//   - dec_t: decoded instruction classes passed from insn_decode32 to the FSM
package mc_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IF     = 3'd0,
    S_ID     = 3'd1,
    S_EX     = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_IOWAIT = 3'd5
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  localparam logic [21:0] IO_PAGE_DEF    = 22'h3FFFFF;
  localparam logic [7:0]  IO_TIMEOUT_DEF = 8'd255;

  typedef struct packed {
    logic r_format;
    logic i_format;
    logic lw;
    logic sw;
    logic beq;
    logic bne;
    logic j;
    logic jal;
    logic jr;
    logic sftmd;
    logic legal;
  } dec_t;

  // Shift-class R-format functs: sll, srl, sra, sllv, srlv, srav.
  function automatic logic is_shift(input logic [5:0] fn);
    case (fn)
      6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07: return 1'b1;
      default:                                  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/insn_decode32.sv
// insn_decode32: purely combinational instruction-class decode.
//   op   - instruction[31:26]
//   func - instruction[5:0]
//   dec  - class flags (R/I format, lw, sw, beq, bne, j, jal, jr, shift, legal)
module insn_decode32
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] func,
  output dec_t       dec
);

  logic r_fmt, i_fmt, is_lw, is_sw, is_beq, is_bne, is_j, is_jal;

  assign r_fmt  = (op == OP_RTYPE);
  assign i_fmt  = (op[5:3] == 3'b001);
  assign is_lw  = (op == OP_LW);
  assign is_sw  = (op == OP_SW);
  assign is_beq = (op == OP_BEQ);
  assign is_bne = (op == OP_BNE);
  assign is_j   = (op == OP_J);
  assign is_jal = (op == OP_JAL);

  always_comb begin
    dec          = '0;
    dec.r_format = r_fmt;
    dec.i_format = i_fmt;
    dec.lw       = is_lw;
    dec.sw       = is_sw;
    dec.beq      = is_beq;
    dec.bne      = is_bne;
    dec.j        = is_j;
    dec.jal      = is_jal;
    dec.jr       = r_fmt && (func == FN_JR);
    dec.sftmd    = r_fmt && is_shift(func);
    dec.legal    = r_fmt | i_fmt | is_lw | is_sw | is_beq | is_bne | is_j | is_jal;
  end

endmodule

// File: rtl/mc_control32.sv
// mc_control32: multi-cycle control FSM (IF/ID/EX/MEM/WB/IOWAIT) with
// memory-mapped I/O wait and timeout.
//   clock, rst_n          - clock, async active-low reset
//   Op, Func              - IR fields, stable for the whole instruction
//   Alu_resultHigh        - ALU result [31:10], compared against IO_PAGE
//   Zero                  - ALU zero flag (EX)
//   io_ready              - I/O completion handshake
//   strobes/steering      - datapath controls, decoded from state + inputs
//   io_err, illegal_op    - single-cycle error pulses
//   state                 - current FSM state for debug
// Outputs are combinational from the state register and the stable
// instruction inputs; they are forced low while rst_n is low so that reset
// takes effect on the outputs without waiting for an edge.
module mc_control32
  import mc_ctrl_pkg::*;
#(
  parameter logic [21:0] IO_PAGE    = IO_PAGE_DEF,
  parameter logic [7:0]  IO_TIMEOUT = IO_TIMEOUT_DEF
) (
  input  logic        clock,
  input  logic        rst_n,
  input  logic [5:0]  Op,
  input  logic [5:0]  Func,
  input  logic [21:0] Alu_resultHigh,
  input  logic        Zero,
  input  logic        io_ready,
  output logic        PCWrite,
  output logic        IRWrite,
  output logic        RegWrite,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        IORead,
  output logic        IOWrite,
  output logic        MemorIOtoReg,
  output logic        RegDST,
  output logic        ALUSrc,
  output logic        Sftmd,
  output logic        Jr,
  output logic        Jal,
  output logic        Branch,
  output logic        nBranch,
  output logic [1:0]  ALUop,
  output logic        io_err,
  output logic        illegal_op,
  output logic [2:0]  state
);

  state_t     st;
  logic [7:0] cnt;
  dec_t       d;
  logic       io, br_take, steer;

  insn_decode32 u_dec (.op(Op), .func(Func), .dec(d));

  assign io      = (Alu_resultHigh == IO_PAGE);
  assign br_take = (d.beq & Zero) | (d.bne & ~Zero);
  // ALU steering stays up while the address is being used in MEM/IOWAIT.
  assign steer   = (st == S_EX) || (st == S_MEM) || (st == S_IOWAIT);
  assign state   = st;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      st  <= S_IF;
      cnt <= '0;
    end else begin
      case (st)
        S_IF: st <= S_ID;
        S_ID: begin
          if (!d.legal || d.j || d.jr) st <= S_IF;
          else if (d.jal)              st <= S_WB;
          else                         st <= S_EX;
        end
        S_EX: begin
          if (d.lw || d.sw)       st <= S_MEM;
          else if (d.beq || d.bne) st <= S_IF;
          else                     st <= S_WB;
        end
        S_MEM: begin
          if (io && !io_ready) begin
            st  <= S_IOWAIT;
            cnt <= '0;
          end else begin
            st <= d.lw ? S_WB : S_IF;
          end
        end
        S_IOWAIT: begin
          // io_ready wins over a coincident timeout.
          if (io_ready)                st <= d.lw ? S_WB : S_IF;
          else if (cnt == IO_TIMEOUT)  st <= S_IF;
          else                         cnt <= cnt + 8'd1;
        end
        S_WB:    st <= S_IF;
        default: st <= S_IF;
      endcase
    end
  end

  always_comb begin
    PCWrite = 1'b0; IRWrite = 1'b0; RegWrite = 1'b0; MemRead = 1'b0;
    MemWrite = 1'b0; IORead = 1'b0; IOWrite = 1'b0; MemorIOtoReg = 1'b0;
    RegDST = 1'b0; ALUSrc = 1'b0; Sftmd = 1'b0; Jr = 1'b0; Jal = 1'b0;
    Branch = 1'b0; nBranch = 1'b0; ALUop = 2'b00; io_err = 1'b0;
    illegal_op = 1'b0;
    if (rst_n) begin
      if (steer) begin
        ALUop  = {d.r_format | d.i_format, d.beq | d.bne};
        ALUSrc = ~(d.r_format | d.beq | d.bne);
        Sftmd  = d.sftmd;
      end
      case (st)
        S_IF: begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
        end
        S_ID: begin
          PCWrite    = d.j | d.jr;
          Jr         = d.jr;
          illegal_op = ~d.legal;
        end
        S_EX: begin
          PCWrite = br_take;
          Branch  = d.beq;
          nBranch = d.bne;
        end
        S_MEM: begin
          MemRead  = d.lw & ~io;
          MemWrite = d.sw & ~io;
          IORead   = d.lw & io;
          IOWrite  = d.sw & io;
        end
        S_IOWAIT: begin
          IORead  = d.lw;
          IOWrite = d.sw;
          io_err  = (cnt == IO_TIMEOUT) && !io_ready;
        end
        S_WB: begin
          RegWrite     = 1'b1;
          RegDST       = d.r_format;
          MemorIOtoReg = d.lw;
          Jal          = d.jal;
          PCWrite      = d.jal;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_control32.sv
// tb_mc_control32: directed instruction sequences; each cycle the expected
// state and output vector is queued, and a negedge monitor pops and compares.
module tb_mc_control32;

  localparam logic [2:0] SIF = 3'd0, SID = 3'd1, SEX = 3'd2, SMEM = 3'd3,
                         SWB = 3'd4, SIOW = 3'd5;

  localparam logic [18:0] PCW  = 19'd1 << 0,  IRW  = 19'd1 << 1,
                          RGW  = 19'd1 << 2,  MRD  = 19'd1 << 3,
                          MWR  = 19'd1 << 4,  IORD = 19'd1 << 5,
                          IOWR = 19'd1 << 6,  M2R  = 19'd1 << 7,
                          RDST = 19'd1 << 8,  ASRC = 19'd1 << 9,
                          SFT  = 19'd1 << 10, JR   = 19'd1 << 11,
                          JAL  = 19'd1 << 12, BR   = 19'd1 << 13,
                          NBR  = 19'd1 << 14, AOPR = 19'd2 << 15,
                          AOPB = 19'd1 << 15, IOER = 19'd1 << 17,
                          ILL  = 19'd1 << 18;

  logic        clock = 1'b0;
  logic        rst_n;
  logic [5:0]  Op, Func;
  logic [21:0] Alu_resultHigh;
  logic        Zero, io_ready;
  logic        PCWrite, IRWrite, RegWrite, MemRead, MemWrite, IORead, IOWrite;
  logic        MemorIOtoReg, RegDST, ALUSrc, Sftmd, Jr, Jal, Branch, nBranch;
  logic [1:0]  ALUop;
  logic        io_err, illegal_op;
  logic [2:0]  state;

  always #5 clock = ~clock;

  mc_control32 dut (
    .clock(clock), .rst_n(rst_n), .Op(Op), .Func(Func),
    .Alu_resultHigh(Alu_resultHigh), .Zero(Zero), .io_ready(io_ready),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .MemRead(MemRead), .MemWrite(MemWrite), .IORead(IORead),
    .IOWrite(IOWrite), .MemorIOtoReg(MemorIOtoReg), .RegDST(RegDST),
    .ALUSrc(ALUSrc), .Sftmd(Sftmd), .Jr(Jr), .Jal(Jal), .Branch(Branch),
    .nBranch(nBranch), .ALUop(ALUop), .io_err(io_err),
    .illegal_op(illegal_op), .state(state)
  );

  logic [21:0] act;
  assign act = {state, illegal_op, io_err, ALUop, nBranch, Branch, Jal, Jr,
                Sftmd, ALUSrc, RegDST, MemorIOtoReg, IOWrite, IORead,
                MemWrite, MemRead, RegWrite, IRWrite, PCWrite};

  typedef struct {
    string       name;
    logic [21:0] v;
  } sb_t;

  sb_t q[$];
  int  n_chk = 0, n_fail = 0, drain = 0;
  bit  done = 1'b0, fin = 1'b0;

  // Monitor: one comparison per queued expectation, at the falling edge.
  always @(negedge clock) begin
    sb_t e;
    int  nf;
    nf = n_fail;
    if (q.size() > 0) begin
      e = q.pop_front();
      n_chk <= n_chk + 1;
      if (act !== e.v) begin
        nf = nf + 1;
        $display("FAIL %s: got state=%0d sig=%05h, want state=%0d sig=%05h",
                 e.name, act[21:19], act[18:0], e.v[21:19], e.v[18:0]);
      end
    end
    if (done && !fin) begin
      drain <= drain + 1;
      if (q.size() == 0) fin <= 1'b1;
      else if (drain >= 60) begin
        nf = nf + 1;
        $display("FAIL drain: got %0d entries left, want 0", q.size());
        fin <= 1'b1;
      end
    end
    n_fail <= nf;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input string nm, input logic [2:0] s, input logic [18:0] v);
    sb_t e;
    e.name = nm;
    e.v    = {s, v};
    q.push_back(e);
  endtask

  task automatic cyc(input string nm, input logic [2:0] s, input logic [18:0] v);
    tick();
    push(nm, s, v);
  endtask

  // IF cycle of a new instruction; IR fields change here only.
  task automatic issue(input string nm, input logic [5:0] op, input logic [5:0] fn);
    cyc({nm, " IF"}, SIF, PCW | IRW);
    Op   = op;
    Func = fn;
  endtask

  initial begin
    rst_n = 1'b0; Op = '0; Func = '0; Alu_resultHigh = '0;
    Zero = 1'b0; io_ready = 1'b0;

    cyc("reset", SIF, '0);

    // addu from reset: 0,1,2,4
    tick(); rst_n = 1'b1; Op = 6'h00; Func = 6'h21;
    push("addu IF", SIF, PCW | IRW);
    cyc("addu ID", SID, '0);
    cyc("addu EX", SEX, AOPR);
    cyc("addu WB", SWB, RGW | RDST);

    // lw to memory
    issue("lw", 6'h23, 6'h00); Alu_resultHigh = 22'h000001;
    cyc("lw ID", SID, '0);
    cyc("lw EX", SEX, ASRC);
    cyc("lw MEM", SMEM, MRD | ASRC);
    cyc("lw WB", SWB, RGW | M2R);

    // sw to I/O, io_ready on the third IOWAIT cycle
    issue("swio", 6'h2B, 6'h00); Alu_resultHigh = 22'h3FFFFF;
    cyc("swio ID", SID, '0);
    cyc("swio EX", SEX, ASRC);
    cyc("swio MEM", SMEM, IOWR | ASRC);
    cyc("swio W1", SIOW, IOWR | ASRC);
    cyc("swio W2", SIOW, IOWR | ASRC);
    cyc("swio W3", SIOW, IOWR | ASRC); io_ready = 1'b1;

    // lw to I/O that never completes
    issue("lwto", 6'h23, 6'h00); io_ready = 1'b0;
    cyc("lwto ID", SID, '0);
    cyc("lwto EX", SEX, ASRC);
    cyc("lwto MEM", SMEM, IORD | ASRC);
    for (int i = 0; i < 255; i++) cyc("lwto WAIT", SIOW, IORD | ASRC);
    cyc("lwto TIMEOUT", SIOW, IORD | ASRC | IOER);

    // branches
    issue("beqT", 6'h04, 6'h00); Zero = 1'b1;
    cyc("beqT ID", SID, '0);
    cyc("beqT EX", SEX, PCW | BR | AOPB);
    issue("beqN", 6'h04, 6'h00); Zero = 1'b0;
    cyc("beqN ID", SID, '0);
    cyc("beqN EX", SEX, BR | AOPB);
    issue("bneZ", 6'h05, 6'h00); Zero = 1'b1;
    cyc("bneZ ID", SID, '0);
    cyc("bneZ EX", SEX, NBR | AOPB);
    issue("bneT", 6'h05, 6'h00); Zero = 1'b0;
    cyc("bneT ID", SID, '0);
    cyc("bneT EX", SEX, PCW | NBR | AOPB);

    // illegal, jumps
    issue("ill", 6'h3F, 6'h00);
    cyc("ill ID", SID, ILL);
    issue("j", 6'h02, 6'h00);
    cyc("j ID", SID, PCW);
    issue("jr", 6'h00, 6'h08);
    cyc("jr ID", SID, PCW | JR);
    issue("jal", 6'h03, 6'h00);
    cyc("jal ID", SID, '0);
    cyc("jal WB", SWB, RGW | JAL | PCW);

    // I-format and shift R-format
    issue("addi", 6'h08, 6'h00);
    cyc("addi ID", SID, '0);
    cyc("addi EX", SEX, AOPR | ASRC);
    cyc("addi WB", SWB, RGW);
    issue("sll", 6'h00, 6'h00);
    cyc("sll ID", SID, '0);
    cyc("sll EX", SEX, AOPR | SFT);
    cyc("sll WB", SWB, RGW | RDST);

    // reset asserted during WB of addu
    issue("addr", 6'h00, 6'h21);
    cyc("addr ID", SID, '0);
    cyc("addr EX", SEX, AOPR);
    tick(); #1 rst_n = 1'b0;
    push("rst async", SIF, '0);
    cyc("rst held", SIF, '0);
    tick(); rst_n = 1'b1;
    push("addr2 IF", SIF, PCW | IRW);
    cyc("addr2 ID", SID, '0);
    cyc("addr2 EX", SEX, AOPR);
    cyc("addr2 WB", SWB, RGW | RDST);
    cyc("final IF", SIF, PCW | IRW);

    done = 1'b1;
    wait (fin);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mc_control32.md
MC_CONTROL32 -- requirements
Module: mc_control32

Interface
REQ-001 Parameter IO_PAGE, default 22'h3FFFFF, ALU result high bits [31:10] that select I/O space.
REQ-002 Parameter IO_TIMEOUT, default 8'd255, maximum cycles spent in IOWAIT before abort.
REQ-003 clock  in  1  system clock; all state changes on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 Op  in  6  instruction[31:26] from the datapath IR; stable from ID through WB.
REQ-006 Func  in  6  instruction[5:0]; stable from ID through WB.
REQ-007 Alu_resultHigh  in  22  ALU result bits [31:10], valid in MEM and IOWAIT.
REQ-008 Zero  in  1  ALU zero flag, valid in EX.
REQ-009 io_ready  in  1  I/O device completion handshake.
REQ-010 PCWrite, IRWrite, RegWrite, MemRead, MemWrite, IORead, IOWrite, MemorIOtoReg  out  1 each  datapath strobes.
REQ-011 RegDST, ALUSrc, Sftmd, Jr, Jal, Branch, nBranch  out  1 each  decoded steering; ALUop  out  2  ALU class.
REQ-012 io_err  out  1  one-cycle pulse on I/O timeout; illegal_op  out  1  one-cycle pulse on unknown opcode.
REQ-013 state  out  3  current FSM state, for debug.

Function
REQ-014 States SHALL be IF=0, ID=1, EX=2, MEM=3, WB=4, IOWAIT=5; codes 6 and 7 SHALL go to IF.
REQ-015 IF: IRWrite=1, PCWrite=1 (PC+4); next state ID.
REQ-016 ID: j (000010) SHALL go to IF with PCWrite=1; jr SHALL go to IF with PCWrite=1 and Jr=1; jal SHALL go to WB; every other legal op SHALL go to EX.
REQ-017 Legal ops: R-format, 001xxx I-format, lw, sw, beq, bne, j, jal; any other op in ID SHALL pulse illegal_op and go to IF without writes.
REQ-018 EX: lw/sw go to MEM; beq/bne go to IF, with PCWrite=1 iff (Branch and Zero) or (nBranch and not Zero); R/I-format go to WB.
REQ-019 ALUop SHALL equal {R_format or I_format, Branch or nBranch}; ALUSrc=0 only for Op=000000 and beq/bne; Sftmd=1 for R-format with Func in {00,02,03,04,06,07}.
REQ-020 MEM: io = (Alu_resultHigh == IO_PAGE); MemRead = lw and not io; MemWrite = sw and not io; IORead = lw and io; IOWrite = sw and io.
REQ-021 MEM, memory access: lw goes to WB, sw goes to IF, one cycle each.
REQ-022 MEM, I/O access: if io_ready=1, same exits as REQ-021; otherwise go to IOWAIT and clear the 8-bit timeout counter.
REQ-023 IOWAIT: hold IORead/IOWrite asserted; exit as in REQ-021 on io_ready=1; otherwise increment the counter.
REQ-024 IOWAIT: when the counter equals IO_TIMEOUT and io_ready=0, pulse io_err and go to IF with no RegWrite; io_ready takes priority when both occur in the same cycle.
REQ-025 WB: RegWrite=1 for exactly one cycle; RegDST=R_format; MemorIOtoReg=1 for lw; Jal=1 (write $31, PCWrite=1) for jal; next state IF.
REQ-026 jr SHALL never assert RegWrite.
REQ-027 All strobes SHALL be Moore outputs of state plus Op/Func/Zero/Alu_resultHigh; no strobe asserted outside its named state.
REQ-028 An instruction SHALL take IF..WB cycles only: R/I 4, lw 5, sw 4, beq/bne 3, j/jr 2, jal 3, plus IOWAIT cycles.

Reset
REQ-029 rst_n=0 SHALL immediately force state=IF, counter=0, and every output to 0 (state output 0).
REQ-030 Reset mid-instruction SHALL abort it with no write strobe issued; after release, the first rising edge SHALL execute IF.

Structure
REQ-031 Package mc_ctrl_pkg SHALL hold the state encodings, opcode/funct constants, IO_PAGE, and IO_TIMEOUT defaults.
REQ-032 Combinational decode (R_format, I_format, lw, sw, branch, jump classes, Sftmd) SHALL be in sub-module insn_decode32; mc_control32 holds the FSM and the counter.

Verification
REQ-033 addu (Op 00, Func 21) from reset -> states 0,1,2,4,0; RegWrite=1 only in WB; RegDST=1; ALUop=10.
REQ-034 lw with Alu_resultHigh=22'h000001 -> MemRead in MEM, WB has MemorIOtoReg=1 and RegWrite=1; 5 cycles total.
REQ-035 sw with Alu_resultHigh=3FFFFF, io_ready rising 3 cycles after MEM -> IOWrite held 4 cycles, then IF; MemWrite never set.
REQ-036 lw to I/O with io_ready=0 for 300 cycles -> io_err pulse after 256 IOWAIT cycles, RegWrite never set, FSM in IF.
REQ-037 beq Zero=1 -> PCWrite in EX; bne Zero=1 -> no PCWrite; Op=111111 -> illegal_op pulse in ID, then IF.
REQ-038 rst_n=0 asserted in WB of addu -> outputs 0 asynchronously, RegWrite not seen on the next edge, restart at IF.
